// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronizer, glitch filter, lock-up FSM,
// step/direction strobes and a saturating illegal-transition counter.
module quad_step_decoder #(
  parameter int unsigned P_FILTER_LEN  = 4,
  parameter int unsigned P_ERR_CNT_BIT = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enc_a,
  input  logic                     enc_b,
  input  logic                     clr,
  output logic                     step_en,
  output logic                     step_dir,
  output logic                     err_pulse,
  output logic [P_ERR_CNT_BIT-1:0] err_count,
  output logic                     locked
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] FLT_MAX  = CW'(P_FILTER_LEN - 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(P_FILTER_LEN);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t st_q, st_d;

  // Phase vectors are {A, B}.
  logic [1:0]         s1_q, s1_d;
  logic [1:0]         s2_q, s2_d;
  logic [1:0]         s2p_q, s2p_d;
  logic [1:0]         filt_q, filt_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]      stab_q, stab_d;
  logic [1:0]         prev_q, prev_d;

  logic                     step_en_q, step_en_d;
  logic                     step_dir_q, step_dir_d;
  logic                     err_pulse_q, err_pulse_d;
  logic [P_ERR_CNT_BIT-1:0] err_cnt_q, err_cnt_d;
  logic                     locked_q, locked_d;
  logic                     err_hit;

  always_comb begin
    s1_d        = {enc_a, enc_b};
    s2_d        = s1_q;
    s2p_d       = s2_q;
    st_d        = st_q;
    filt_d      = filt_q;
    cnt_d       = cnt_q;
    stab_d      = stab_q;
    prev_d      = prev_q;
    step_en_d   = 1'b0;
    err_pulse_d = 1'b0;
    step_dir_d  = step_dir_q;
    locked_d    = locked_q;
    err_hit     = 1'b0;

    unique case (st_q)
      ST_INIT: begin
        // Track the pins until they have been quiet long enough.
        filt_d = s2_q;
        cnt_d  = '0;
        if (s2_q != s2p_q) begin
          stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
          stab_d = stab_q + 1'b1;
        end
        if (stab_q == STAB_MAX) begin
          st_d     = ST_RUN;
          prev_d   = filt_q;
          locked_d = 1'b1;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < 2; i++) begin
          if (s2_q[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == FLT_MAX) begin
            filt_d[i] = s2_q[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end

        prev_d = filt_q;

        // Plus order 00->01->11->10: next = {B, ~A}.
        unique case (1'b1)
          ((filt_q ^ prev_q) == 2'b11): begin
            err_pulse_d = 1'b1;
            err_hit     = 1'b1;
          end
          (filt_q == {prev_q[0], ~prev_q[1]}): begin
            step_en_d  = 1'b1;
            step_dir_d = 1'b1;
          end
          (filt_q == {~prev_q[0], prev_q[1]}): begin
            step_en_d  = 1'b1;
            step_dir_d = 1'b0;
          end
          default: ;
        endcase
      end

      default: ;
    endcase

    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if (err_hit && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st_q        <= ST_INIT;
      s1_q        <= '0;
      s2_q        <= '0;
      s2p_q       <= '0;
      filt_q      <= '0;
      cnt_q       <= '0;
      stab_q      <= '0;
      prev_q      <= '0;
      step_en_q   <= 1'b0;
      step_dir_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      st_q        <= st_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s2p_q       <= s2p_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      prev_q      <= prev_d;
      step_en_q   <= step_en_d;
      step_dir_q  <= step_dir_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign step_en   = step_en_q;
  assign step_dir  = step_dir_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign locked    = locked_q;

endmodule
